// File: rtl/ascii_num_splitter.sv
// ascii_num_splitter: splits a raw ASCII byte stream into numeric tokens and
// drives the ascii_to_int32 converter's start / char_valid / num_end protocol,
// one token at a time, waiting for result_valid between tokens.
module ascii_num_splitter #(
  parameter int MAX_CHARS = 11,
  parameter int CNT_W     = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [7:0]       in_data,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             flush,
  output logic             conv_start,
  output logic [7:0]       conv_char,
  output logic             conv_char_valid,
  output logic             conv_num_end,
  input  logic             conv_result_valid,
  output logic [CNT_W-1:0] token_count,
  output logic             err_invalid,
  output logic             err_overlong,
  output logic             busy
);

  localparam int LEN_W = $clog2(MAX_CHARS + 1);

  typedef enum logic [2:0] {
    IDLE, SEND_START, SEND_CHAR, IN_NUM, SEND_END, WAIT_RES
  } state_t;

  state_t           state, state_nx;
  logic [7:0]       hold, hold_nx;
  logic [LEN_W-1:0] len, len_nx;
  logic [7:0]       char_nx;
  logic             start_nx, cv_nx, end_nx;
  logic             set_inv, set_ovl, cnt_inc;
  logic             is_digit, is_minus, is_sep, accept;

  assign is_digit = (in_data >= 8'h30) && (in_data <= 8'h39);
  assign is_minus = (in_data == 8'h2D);
  assign is_sep   = (in_data == 8'h20) || (in_data == 8'h09) || (in_data == 8'h2C) ||
                    (in_data == 8'h0D) || (in_data == 8'h0A);

  // Only IDLE and IN_NUM take bytes; flush blocks acceptance so it never
  // races with a byte in the same cycle.
  assign in_ready = ((state == IDLE) || (state == IN_NUM)) && !flush;
  assign accept   = in_valid && in_ready;
  assign busy     = (state != IDLE);

  // Next-state and next-output decode; converter outputs are the registered
  // image of the decisions made here, so each pulse lines up with its state.
  always_comb begin
    state_nx = state;
    hold_nx  = hold;
    len_nx   = len;
    char_nx  = conv_char;
    start_nx = 1'b0;
    cv_nx    = 1'b0;
    end_nx   = 1'b0;
    set_inv  = 1'b0;
    set_ovl  = 1'b0;
    cnt_inc  = 1'b0;
    case (state)
      IDLE: begin
        if (accept) begin
          if (is_digit || is_minus) begin
            hold_nx  = in_data;
            len_nx   = LEN_W'(1);
            state_nx = SEND_START;
            start_nx = 1'b1;
          end else if (!is_sep) begin
            set_inv = 1'b1;
          end
        end
      end
      SEND_START: begin
        // First char goes out the cycle after start, never with it.
        state_nx = SEND_CHAR;
        cv_nx    = 1'b1;
        char_nx  = hold;
      end
      SEND_CHAR: state_nx = IN_NUM;
      IN_NUM: begin
        if (flush) begin
          state_nx = SEND_END;
          end_nx   = 1'b1;
        end else if (accept) begin
          if (is_digit) begin
            if (len < LEN_W'(MAX_CHARS)) begin
              cv_nx   = 1'b1;
              char_nx = in_data;
              len_nx  = len + LEN_W'(1);
            end else begin
              // Excess digit is swallowed; the token stays open.
              set_ovl = 1'b1;
            end
          end else begin
            // Separator, mid-token minus or junk all close the token and
            // are consumed; only the latter two are errors.
            state_nx = SEND_END;
            end_nx   = 1'b1;
            if (!is_sep) set_inv = 1'b1;
          end
        end
      end
      SEND_END: state_nx = WAIT_RES;
      WAIT_RES: begin
        if (conv_result_valid) begin
          cnt_inc  = 1'b1;
          len_nx   = '0;
          state_nx = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  // State, token bookkeeping and registered converter outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state           <= IDLE;
      hold            <= 8'h00;
      len             <= '0;
      conv_start      <= 1'b0;
      conv_char       <= 8'h00;
      conv_char_valid <= 1'b0;
      conv_num_end    <= 1'b0;
    end else begin
      state           <= state_nx;
      hold            <= hold_nx;
      len             <= len_nx;
      conv_start      <= start_nx;
      conv_char       <= char_nx;
      conv_char_valid <= cv_nx;
      conv_num_end    <= end_nx;
    end
  end

  // Token counter (wraps) and sticky error flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      token_count  <= '0;
      err_invalid  <= 1'b0;
      err_overlong <= 1'b0;
    end else begin
      if (cnt_inc) token_count <= token_count + CNT_W'(1);
      if (set_inv) err_invalid <= 1'b1;
      if (set_ovl) err_overlong <= 1'b1;
    end
  end

endmodule

// File: tb/tb_ascii_num_splitter.sv
// tb_ascii_num_splitter: directed and random byte streams checked against a
// string-level tokenizer model, with a converter model answering num_end.
module tb_ascii_num_splitter;
  localparam int MAX = 11;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [7:0]  in_data = 8'h00;
  logic        in_valid = 1'b0;
  logic        flush = 1'b0;
  logic        conv_result_valid = 1'b0;
  logic        in_ready, conv_start, conv_char_valid, conv_num_end;
  logic [7:0]  conv_char;
  logic [15:0] token_count;
  logic        err_invalid, err_overlong, busy;

  ascii_num_splitter #(.MAX_CHARS(MAX), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .flush(flush), .conv_start(conv_start),
    .conv_char(conv_char), .conv_char_valid(conv_char_valid),
    .conv_num_end(conv_num_end), .conv_result_valid(conv_result_valid),
    .token_count(token_count), .err_invalid(err_invalid),
    .err_overlong(err_overlong), .busy(busy)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h @%0t", tag, obs, exp, $time);
    end
  endtask

  // 0 digit, 1 minus, 2 separator, 3 invalid
  function automatic int cls(input logic [7:0] b);
    if (b >= "0" && b <= "9") return 0;
    if (b == "-") return 1;
    if (b == " " || b == 8'h09 || b == "," || b == 8'h0D || b == 8'h0A) return 2;
    return 3;
  endfunction

  // ---------------- reference model (string tokenizer) ----------------
  string exp_q[$];
  int    exp_cnt = 0;
  bit    exp_inv = 0, exp_ovl = 0;
  bit    m_open = 0;
  string m_tok;

  task automatic model(input int items[$]);
    logic [7:0] b;
    int c;
    foreach (items[i]) begin
      if (items[i] < 0) begin
        if (m_open) begin exp_q.push_back(m_tok); exp_cnt++; m_open = 0; end
      end else begin
        b = 8'(items[i]);
        c = cls(b);
        if (!m_open) begin
          if (c <= 1) begin m_open = 1; m_tok = $sformatf("%c", b); end
          else if (c == 3) exp_inv = 1;
        end else if (c == 0) begin
          if (m_tok.len() < MAX) m_tok = $sformatf("%s%c", m_tok, b);
          else exp_ovl = 1;
        end else begin
          if (c != 2) exp_inv = 1;
          exp_q.push_back(m_tok); exp_cnt++; m_open = 0;
        end
      end
    end
  endtask

  // ---------------- converter model ----------------
  int conv_dly = 0;  // 0 = random 1..5
  initial begin
    int d;
    forever begin
      @(posedge clk); #1;
      if (rst_n && conv_num_end) begin
        d = (conv_dly > 0) ? conv_dly : $urandom_range(1, 5);
        repeat (d) @(posedge clk);
        #1 conv_result_valid = 1'b1;
        @(posedge clk);
        #1 conv_result_valid = 1'b0;
      end
    end
  end

  // ---------------- protocol monitor ----------------
  bit    mon_open = 0, waiting = 0, prev_start = 0, prev_rv = 0;
  bit    exp_start_nx = 0, exp_end_nx = 0;
  int    seen_cnt = 0;
  string obs;
  initial begin
    string e;
    int have;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        mon_open = 0; waiting = 0; prev_start = 0; prev_rv = 0;
        exp_start_nx = 0; exp_end_nx = 0; seen_cnt = 0;
      end else begin
        if (exp_start_nx) chk("start_lat", conv_start, 1);
        if (exp_end_nx)   chk("end_lat", conv_num_end, 1);
        if (prev_start)   chk("char_after_start", conv_char_valid, 1);
        if (prev_rv) begin
          chk("count_after_res", token_count, seen_cnt);
          chk("idle_after_res", busy, 0);
        end
        if (waiting && !conv_num_end) begin
          chk("rdy_in_wait", in_ready, 0);
          chk("cnt_hold_wait", token_count, seen_cnt);
        end
        exp_start_nx = 0;
        exp_end_nx   = 0;
        if (in_valid && in_ready && !busy && cls(in_data) <= 1) exp_start_nx = 1;
        if (in_valid && in_ready && busy && cls(in_data) != 0) exp_end_nx = 1;
        if (flush && busy) exp_end_nx = 1;
        if (conv_start) begin
          chk("start_no_char", conv_char_valid, 0);
          chk("start_when_closed", mon_open, 0);
          mon_open = 1;
          obs = "";
        end
        if (conv_char_valid) begin
          chk("char_in_token", mon_open, 1);
          obs = $sformatf("%s%c", obs, conv_char);
        end
        if (conv_num_end) begin
          mon_open = 0;
          waiting  = 1;
          have = (exp_q.size() > 0) ? 1 : 0;
          chk("token_expected", have, 1);
          if (have != 0) begin
            e = exp_q.pop_front();
            chk("token_len", obs.len(), e.len());
            for (int i = 0; i < obs.len() && i < e.len(); i++)
              chk("token_char", obs[i], e[i]);
          end
        end
        prev_rv = conv_result_valid;
        if (conv_result_valid) begin waiting = 0; seen_cnt++; end
        prev_start = conv_start;
      end
    end
  end

  // ---------------- driver ----------------
  bit gaps = 0;

  task automatic wait_rdy();
    int k;
    for (k = 0; k < 200; k++) begin
      @(negedge clk);
      if (in_ready) break;
    end
    chk("ready_timeout", (k < 200), 1);
  endtask

  task automatic drive(input int items[$]);
    @(posedge clk); #1;
    foreach (items[i]) begin
      if (items[i] < 0) begin
        in_valid = 1'b0;
        wait_rdy();
        @(posedge clk); #1 flush = 1'b1;
        @(posedge clk); #1 flush = 1'b0;
      end else begin
        if (gaps && $urandom_range(0, 4) == 0) begin
          in_valid = 1'b0;
          @(posedge clk); #1;
        end
        in_valid = 1'b1;
        in_data  = 8'(items[i]);
        wait_rdy();
        @(posedge clk); #1;
      end
    end
    in_valid = 1'b0;
  endtask

  task automatic end_check();
    int k;
    for (k = 0; k < 300; k++) begin
      @(negedge clk);
      if (!busy && !mon_open && !waiting && exp_q.size() == 0) break;
    end
    chk("drain", (k < 300), 1);
    chk("token_count", token_count, exp_cnt[15:0]);
    chk("err_invalid", err_invalid, exp_inv);
    chk("err_overlong", err_overlong, exp_ovl);
  endtask

  task automatic run_items(input int items[$]);
    model(items);
    drive(items);
    end_check();
  endtask

  task automatic run_str(input string s, input bit add_flush);
    int items[$];
    for (int i = 0; i < s.len(); i++) items.push_back(int'(s[i]));
    if (add_flush) items.push_back(-1);
    run_items(items);
  endtask

  initial begin
    logic [7:0] junk [5];
    int items[$];
    int r;
    junk[0] = "a"; junk[1] = "."; junk[2] = "+"; junk[3] = 8'h00; junk[4] = 8'hFF;

    repeat (3) @(negedge clk);
    chk("rst_start", conv_start, 0);
    chk("rst_cv", conv_char_valid, 0);
    chk("rst_end", conv_num_end, 0);
    chk("rst_char", conv_char, 0);
    chk("rst_count", token_count, 0);
    chk("rst_errs", {err_invalid, err_overlong}, 0);
    chk("rst_busy", busy, 0);
    chk("rst_ready", in_ready, 1);
    @(posedge clk); #1 rst_n = 1'b1;

    // directed streams, in_valid held
    run_str("12 -34\n", 0);
    run_str(" ,\t5,", 0);
    conv_dly = 5;
    run_str("7", 1);
    conv_dly = 0;
    run_str("1-2 ", 0);
    run_str("123456789012 ", 0);

    // reset in the middle of token "45"
    @(posedge clk); #1;
    in_valid = 1'b1; in_data = "4"; wait_rdy();
    @(posedge clk); #1 in_data = "5"; wait_rdy();
    @(posedge clk); #1 in_valid = 1'b0;
    @(posedge clk); #1;
    chk("pre_rst_busy", busy, 1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_end", conv_num_end, 0);
    chk("mid_rst_cv", conv_char_valid, 0);
    chk("mid_rst_count", token_count, 0);
    chk("mid_rst_errs", {err_invalid, err_overlong}, 0);
    exp_q.delete(); exp_cnt = 0; exp_inv = 0; exp_ovl = 0; m_open = 0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    run_str("8 ", 0);

    // random streams
    gaps = 1;
    for (int s = 0; s < 25; s++) begin
      items.delete();
      for (int n = 0; n < 30; n++) begin
        r = $urandom_range(0, 99);
        if (r < 50)      items.push_back(int'($urandom_range(8'h30, 8'h39)));
        else if (r < 70) begin
          case ($urandom_range(0, 4))
            0: items.push_back(32'h20);
            1: items.push_back(32'h09);
            2: items.push_back(32'h2C);
            3: items.push_back(32'h0D);
            default: items.push_back(32'h0A);
          endcase
        end
        else if (r < 78) items.push_back(32'h2D);
        else if (r < 85) items.push_back(int'(junk[$urandom_range(0, 4)]));
        else if (r < 92) items.push_back(-1);
        else for (int k = 0; k < 13; k++) items.push_back(int'($urandom_range(8'h30, 8'h39)));
      end
      items.push_back(32'h20);
      run_items(items);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

endmodule
